// File: rtl/serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB first, with a registered carry.
// Operands enter through a valid/ready handshake and the result leaves through another.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

    if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_err
        $error("serial_adder: WIDTH must be a nonzero multiple of CHUNK");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic               ovf_q, ovf_d;
    logic               valid_q, valid_d;

    logic [CHUNK:0]     chunk_sum;
    logic [WIDTH-1:0]   res_next;
    logic               msb_cin;

    always_comb begin
        chunk_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + (CHUNK+1)'(carry_q);
        // Carry into the top bit of this chunk; on the last chunk it is the carry into bit WIDTH-1.
        msb_cin   = chunk_sum[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
        res_next  = (res_q >> CHUNK) | (WIDTH'(chunk_sum[CHUNK-1:0]) << (WIDTH - CHUNK));

        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = in_a;
                    // Subtract is A + ~B + !cin.
                    b_d     = in_sub ? ~in_b : in_b;
                    carry_d = in_cin ^ in_sub;
                    cnt_d   = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                res_d   = res_next;
                carry_d = chunk_sum[CHUNK];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST_CNT) begin
                    sum_d   = res_next;
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_cin ^ chunk_sum[CHUNK];
                    valid_d = 1'b1;
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StCalc);
    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three configurations (1/1, 8/1, 16/4) driven through a
// scoreboard; expected results come from plain integer arithmetic.
module tb_serial_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
    } exp_t;

    int wid [3] = '{1, 8, 16};
    int nch [3] = '{1, 8, 4};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  in_valid, in_cin, in_sub, out_ready, rdy_force, rnd_rdy;
    logic [15:0] in_a_v [3];
    logic [15:0] in_b_v [3];
    wire  [2:0]  in_ready, out_valid, out_cout, out_ovf, busy;
    wire  [0:0]  sum0;
    wire  [7:0]  sum1;
    wire  [15:0] sum2;
    wire  [15:0] sum_v [3];

    exp_t scb [3][$];
    bit   [2:0] seen;
    int cyc = 0;
    int errors = 0;
    int checks = 0;

    assign sum_v[0] = {15'd0, sum0};
    assign sum_v[1] = {8'd0, sum1};
    assign sum_v[2] = sum2;

    serial_adder #(.WIDTH(1), .CHUNK(1)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_a(in_a_v[0][0:0]), .in_b(in_b_v[0][0:0]), .in_cin(in_cin[0]), .in_sub(in_sub[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_sum(sum0),
        .out_cout(out_cout[0]), .out_ovf(out_ovf[0]), .busy(busy[0])
    );

    serial_adder #(.WIDTH(8), .CHUNK(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_a(in_a_v[1][7:0]), .in_b(in_b_v[1][7:0]), .in_cin(in_cin[1]), .in_sub(in_sub[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_sum(sum1),
        .out_cout(out_cout[1]), .out_ovf(out_ovf[1]), .busy(busy[1])
    );

    serial_adder #(.WIDTH(16), .CHUNK(4)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_a(in_a_v[2]), .in_b(in_b_v[2]), .in_cin(in_cin[2]), .in_sub(in_sub[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_sum(sum2),
        .out_cout(out_cout[2]), .out_ovf(out_ovf[2]), .busy(busy[2])
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: integer arithmetic on the operand values, signed range check for overflow.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub);
        exp_t   e;
        longint m, ua, ub, sa, sbv, r, half;
        m    = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & m;
        ub   = longint'(b) & m;
        r    = sub ? ua - ub - longint'(cin) : ua + ub + longint'(cin);
        e.sum  = 16'(r & m);
        e.cout = sub ? (ua >= ub + longint'(cin)) : (r > m);
        sa   = (ua >= half) ? ua - (m + 1) : ua;
        sbv  = (ub >= half) ? ub - (m + 1) : ub;
        r    = sub ? sa - sbv - longint'(cin) : sa + sbv + longint'(cin);
        e.ovf = (r < -half) || (r >= half);
        e.acc = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [15:0] s, input logic c, input logic o);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.acc = 0;
        return e;
    endfunction

    task automatic push_exp(input int k, input exp_t e);
        exp_t x = e;
        x.acc = cyc;
        scb[k].push_back(x);
    endtask

    // Present one bundle; lit selects the caller's expected values over the model.
    task automatic send(input int k, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input bit lit, input exp_t xe);
        int n = 0;
        @(negedge clk);
        while (!in_ready[k] && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[k]) begin
            chk($sformatf("u%0d in_ready timeout", k), in_ready[k], 1);
            return;
        end
        in_a_v[k] = a; in_b_v[k] = b; in_cin[k] = cin; in_sub[k] = sub; in_valid[k] = 1'b1;
        @(negedge clk);
        in_valid[k] = 1'b0;
        push_exp(k, lit ? xe : model(wid[k], a, b, cin, sub));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((scb[0].size() + scb[1].size() + scb[2].size()) != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("drain", scb[0].size() + scb[1].size() + scb[2].size(), 0);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_ops(input int k, input int n);
        logic [15:0] m;
        exp_t dummy;
        dummy = mk(16'd0, 1'b0, 1'b0);
        m = 16'((32'd1 << wid[k]) - 1);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(k, 16'($urandom) & m, 16'($urandom) & m, 1'($urandom), 1'($urandom), 0, dummy);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            for (int k = 0; k < 3; k++)
                out_ready[k] = rnd_rdy[k] ? 1'($urandom_range(0, 1)) : rdy_force[k];
            #1;
            for (int k = 0; k < 3; k++) begin
                if (rst_n && out_valid[k]) begin
                    chk($sformatf("u%0d in_ready in hold", k), in_ready[k], 0);
                    if (scb[k].size() == 0) begin
                        chk($sformatf("u%0d unexpected out_valid", k), out_valid[k], 0);
                    end else begin
                        e = scb[k][0];
                        if (!seen[k]) begin
                            chk($sformatf("u%0d latency", k), cyc - e.acc, nch[k]);
                            seen[k] = 1'b1;
                        end
                        chk($sformatf("u%0d sum", k), sum_v[k], e.sum);
                        chk($sformatf("u%0d cout", k), out_cout[k], e.cout);
                        chk($sformatf("u%0d ovf", k), out_ovf[k], e.ovf);
                        if (out_ready[k]) begin
                            void'(scb[k].pop_front());
                            seen[k] = 1'b0;
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        exp_t dummy;
        int   n;
        dummy = mk(16'd0, 1'b0, 1'b0);
        in_valid = '0; in_cin = '0; in_sub = '0; out_ready = '0; rdy_force = '1; rnd_rdy = '0;
        seen = '0;
        for (int k = 0; k < 3; k++) begin
            in_a_v[k] = '0;
            in_b_v[k] = '0;
        end
        fork
            forever @(posedge clk) cyc++;
            monitor();
            begin
                #1_000_000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("u%0d reset out_valid", k), out_valid[k], 0);
            chk($sformatf("u%0d reset busy", k), busy[k], 0);
            chk($sformatf("u%0d reset sum", k), sum_v[k], 0);
            chk($sformatf("u%0d reset cout/ovf", k), {out_cout[k], out_ovf[k]}, 0);
            chk($sformatf("u%0d reset in_ready", k), in_ready[k], 1);
        end
        rst_n = 1'b1;

        // One-bit full adder truth table.
        for (int i = 0; i < 8; i++)
            send(0, 16'(i[2]), 16'(i[1]), i[0], 1'b0, 0, dummy);

        send(1, 16'hFF, 16'h01, 0, 0, 1, mk(16'h00, 1, 0));
        send(1, 16'h7F, 16'h01, 0, 0, 1, mk(16'h80, 0, 1));
        send(1, 16'h05, 16'h07, 0, 1, 1, mk(16'hFE, 0, 0));
        send(1, 16'h80, 16'h01, 0, 1, 1, mk(16'h7F, 1, 1));
        send(1, 16'h10, 16'h0F, 1, 1, 1, mk(16'h00, 1, 0));
        send(2, 16'hFFFF, 16'h0001, 0, 0, 1, mk(16'h0000, 1, 0));
        wait_idle();

        // Backpressure: result held while a second bundle waits at the input.
        rdy_force[1] = 1'b0;
        send(1, 16'hA5, 16'h3C, 0, 0, 1, mk(16'hE1, 0, 0));
        n = 0;
        while (!out_valid[1] && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("bp out_valid", out_valid[1], 1);
        repeat (5) begin
            @(negedge clk);
            in_a_v[1] = 16'h11; in_b_v[1] = 16'h22; in_cin[1] = 0; in_sub[1] = 0;
            in_valid[1] = 1'b1;
            #1;
            chk("bp in_ready", in_ready[1], 0);
        end
        @(negedge clk);
        rdy_force[1] = 1'b1;
        @(negedge clk);
        #1;
        chk("bp handoff in_ready", in_ready[1], 1);
        @(negedge clk);
        in_valid[1] = 1'b0;
        push_exp(1, mk(16'h33, 0, 0));
        wait_idle();

        // Reset in the middle of a calculation discards it.
        send(1, 16'hAA, 16'h55, 0, 0, 0, dummy);
        @(negedge clk);
        @(negedge clk);
        chk("midcalc busy", busy[1], 1);
        rst_n = 1'b0;
        @(negedge clk);
        scb[1].delete();
        seen[1] = 1'b0;
        chk("rst out_valid", out_valid[1], 0);
        chk("rst busy", busy[1], 0);
        chk("rst in_ready", in_ready[1], 1);
        rst_n = 1'b1;
        send(1, 16'h12, 16'h34, 0, 0, 1, mk(16'h46, 0, 0));
        wait_idle();

        rnd_rdy = '1;
        fork
            rand_ops(0, 200);
            rand_ops(1, 200);
            rand_ops(2, 1000);
        join
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
